dest_control: RTL and testbench

Read-side (destination-domain) controller of the dual-clock asynchronous FIFO, the counterpart of the write-side source controller. Runs entirely on `clk_d` and brings the source write pointer into this domain through a synchronizer chain. It derives empty status and fill level, accepts read requests, drives the FIFO memory read address, and registers the read data out with a one-cycle valid pulse. Its `read_pointer` output feeds back to the source controller for full/occupancy tracking.

---
 rtl/dest_control.sv | 100 ++++++++++
 tb/tb_dest_control.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dest_control.sv
// Read-side controller of the dual-clock FIFO: synchronizes the write pointer into clk_d,
// derives empty/fill level and registers read data. Optional macro DEST_GRAY_PTR_EN selects Gray pointers.
module dest_control #(
  parameter int DATA_WIDTH  = 8,
  parameter int PTR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_d,
  input  logic                  rst,
  input  logic                  read_signal,
  input  logic [PTR_WIDTH-1:0]  write_pointer,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [PTR_WIDTH-1:0]  read_pointer,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  data_valid,
  output logic                  empty,
  output logic [PTR_WIDTH-1:0]  fill_level,
  output logic                  underflow
);

  logic [PTR_WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [PTR_WIDTH-1:0]  wpSync;
  logic [PTR_WIDTH-1:0]  rdPtr_q, rdPtr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  under_q, under_d;
  logic                  accept;

`ifdef DEST_GRAY_PTR_EN
  logic [PTR_WIDTH-1:0] rdPtrGray_q;

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Only the Gray form crosses domains; arithmetic stays binary.
  assign wpSync       = gray2bin(sync_q[SYNC_STAGES-1]);
  assign read_pointer = rdPtrGray_q;

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      rdPtrGray_q <= '0;
    end else begin
      rdPtrGray_q <= rdPtr_d ^ (rdPtr_d >> 1);
    end
  end
`else
  assign wpSync       = sync_q[SYNC_STAGES-1];
  assign read_pointer = rdPtr_q;
`endif

  assign empty      = (wpSync == rdPtr_q);
  assign fill_level = wpSync - rdPtr_q;
  assign accept     = read_signal & ~empty;
  assign dout       = dout_q;
  assign data_valid = valid_q;
  assign underflow  = under_q;

  always_comb begin
    rdPtr_d = rdPtr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    under_d = under_q;
    if (accept) begin
      rdPtr_d = rdPtr_q + PTR_WIDTH'(1);
      dout_d  = din;
      valid_d = 1'b1;
    end else if (read_signal) begin
      under_d = 1'b1;
    end
  end

  // A stale synchronized write pointer can only make empty look true longer, never shorter.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rdPtr_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      sync_q[0] <= write_pointer;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rdPtr_q <= rdPtr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      under_q <= under_d;
    end
  end

endmodule

// File: tb/tb_dest_control.sv
// Self-checking bench for dest_control: per-cycle vector table plus a read-data scoreboard
// and hand-written reset/latency sequences. Pointer values are encoded per DEST_GRAY_PTR_EN.
module tb_dest_control;

  logic       clk_d = 1'b0;
  logic       rst;
  logic       read_signal;
  logic [2:0] write_pointer;
  logic [7:0] din;
  logic [2:0] read_pointer;
  logic [7:0] dout;
  logic       data_valid;
  logic       empty;
  logic [2:0] fill_level;
  logic       underflow;

  logic [7:0] mem [8];
  logic [7:0] expQ [$];
  int vecCount = 0;
  int missCount = 0;

  typedef struct {
    logic       rd;
    logic [2:0] wp;
    logic       expEmpty;
    logic [2:0] expFill;
    logic [2:0] expRp;
    logic       expValid;
    logic       expUnder;
  } vec_t;

  vec_t vecs [20];

  dest_control #(.DATA_WIDTH(8), .PTR_WIDTH(3), .SYNC_STAGES(2)) dut (
    .clk_d(clk_d), .rst(rst), .read_signal(read_signal), .write_pointer(write_pointer),
    .din(din), .read_pointer(read_pointer), .dout(dout), .data_valid(data_valid),
    .empty(empty), .fill_level(fill_level), .underflow(underflow)
  );

  always #5 clk_d = ~clk_d;

  function automatic logic [2:0] enc(input logic [2:0] b);
`ifdef DEST_GRAY_PTR_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [2:0] dec(input logic [2:0] p);
`ifdef DEST_GRAY_PTR_EN
    logic [2:0] b;
    b[2] = p[2];
    b[1] = b[2] ^ p[1];
    b[0] = b[1] ^ p[0];
    return b;
`else
    return p;
`endif
  endfunction

  assign din = mem[dec(read_pointer)];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic scoreboardCheck();
    if (data_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("sbUnexpectedValid", 8'd1, 8'd0);
      end else begin
        checkOutput("sbDout", dout, expQ.pop_front());
      end
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [2:0] wpBin);
    read_signal   = rd;
    write_pointer = enc(wpBin);
    @(posedge clk_d);
    #1;
    scoreboardCheck();
  endtask

  function automatic vec_t mk(input logic rd, input logic [2:0] wp, input logic e,
                              input logic [2:0] f, input logic [2:0] rp, input logic v,
                              input logic u);
    vec_t r;
    r.rd = rd; r.wp = wp; r.expEmpty = e; r.expFill = f;
    r.expRp = rp; r.expValid = v; r.expUnder = u;
    return r;
  endfunction

  initial begin
    logic [2:0] prevRp;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);

    //           rd  wp  empty fill rp valid under
    vecs[0]  = mk(0, 3, 1, 0, 0, 0, 0);  // sync stage 1 only
    vecs[1]  = mk(0, 3, 0, 3, 0, 0, 0);  // visible after 2 edges
    vecs[2]  = mk(1, 3, 0, 2, 1, 1, 0);
    vecs[3]  = mk(1, 3, 0, 1, 2, 1, 0);
    vecs[4]  = mk(1, 3, 1, 0, 3, 1, 0);
    vecs[5]  = mk(1, 3, 1, 0, 3, 0, 1);  // 4th request underflows
    vecs[6]  = mk(0, 6, 1, 0, 3, 0, 1);
    vecs[7]  = mk(0, 6, 0, 3, 3, 0, 1);
    vecs[8]  = mk(1, 6, 0, 2, 4, 1, 1);
    vecs[9]  = mk(1, 6, 0, 1, 5, 1, 1);
    vecs[10] = mk(1, 7, 1, 0, 6, 1, 1);
    vecs[11] = mk(1, 7, 0, 1, 6, 0, 1);  // was empty at edge: no accept
    vecs[12] = mk(0, 0, 0, 1, 6, 0, 1);
    vecs[13] = mk(1, 0, 0, 1, 7, 1, 1);  // read and wp_sync advance together
    vecs[14] = mk(0, 2, 0, 1, 7, 0, 1);
    vecs[15] = mk(0, 2, 0, 3, 7, 0, 1);  // rp=7, wp=2 across wrap
    vecs[16] = mk(1, 2, 0, 2, 0, 1, 1);
    vecs[17] = mk(1, 2, 0, 1, 1, 1, 1);
    vecs[18] = mk(1, 2, 1, 0, 2, 1, 1);
    vecs[19] = mk(0, 2, 1, 0, 2, 0, 1);

    rst = 1'b1;
    read_signal = 1'b0;
    write_pointer = 3'd0;
    #12;
    checkOutput("rstReadPtr", {5'd0, read_pointer}, {5'd0, enc(3'd0)});
    checkOutput("rstEmpty", {7'd0, empty}, 8'd1);
    checkOutput("rstFill", {5'd0, fill_level}, 8'd0);
    checkOutput("rstValid", {7'd0, data_valid}, 8'd0);
    @(negedge clk_d);
    rst = 1'b0;
    @(posedge clk_d);
    #1;

    prevRp = 3'd0;
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].expValid) expQ.push_back(mem[prevRp]);
      applyStimulus(vecs[i].rd, vecs[i].wp);
      checkOutput($sformatf("v%0d_empty", i), {7'd0, empty}, {7'd0, vecs[i].expEmpty});
      checkOutput($sformatf("v%0d_fill", i), {5'd0, fill_level}, {5'd0, vecs[i].expFill});
      checkOutput($sformatf("v%0d_rdPtr", i), {5'd0, read_pointer}, {5'd0, enc(vecs[i].expRp)});
      checkOutput($sformatf("v%0d_valid", i), {7'd0, data_valid}, {7'd0, vecs[i].expValid});
      checkOutput($sformatf("v%0d_under", i), {7'd0, underflow}, {7'd0, vecs[i].expUnder});
      prevRp = vecs[i].expRp;
    end

    // Bring read_pointer to 5 with a read in flight, then reset asynchronously.
    applyStimulus(1'b0, 3'd5);
    applyStimulus(1'b0, 3'd5);
    checkOutput("preRstFill", {5'd0, fill_level}, 8'd3);
    for (int k = 0; k < 3; k++) begin
      expQ.push_back(mem[3'(2 + k)]);
      applyStimulus(1'b1, 3'd5);
    end
    checkOutput("preRstRdPtr", {5'd0, read_pointer}, {5'd0, enc(3'd5)});
    checkOutput("preRstValid", {7'd0, data_valid}, 8'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstRdPtr", {5'd0, read_pointer}, {5'd0, enc(3'd0)});
    checkOutput("midRstEmpty", {7'd0, empty}, 8'd1);
    checkOutput("midRstFill", {5'd0, fill_level}, 8'd0);
    checkOutput("midRstDout", dout, 8'd0);
    checkOutput("midRstValid", {7'd0, data_valid}, 8'd0);
    checkOutput("midRstUnder", {7'd0, underflow}, 8'd0);
    read_signal = 1'b0;
    write_pointer = enc(3'd0);
    @(negedge clk_d);
    rst = 1'b0;
    applyStimulus(1'b1, 3'd0);
    checkOutput("postRstUnder", {7'd0, underflow}, 8'd1);
    checkOutput("postRstValid", {7'd0, data_valid}, 8'd0);
    checkOutput("sbLeftover", 8'(expQ.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
